// File: rtl/y86_exec_mem_pc_if.sv
// Operand/result bundle between decode/regfile and the execute-memory-PC block.
interface y86_exec_mem_pc_if #(
    parameter int N = 64
);
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [N-1:0] valA;
    logic [N-1:0] valB;
    logic [N-1:0] valC;
    logic [N-1:0] valP;
    logic         Instr_valid;
    logic         imem_error;
    logic [N-1:0] valE;
    logic         cnd;
    logic [N-1:0] valM;
    logic [1:0]   stat;
    logic [N-1:0] PC;

    modport master (
        output icode, ifun, valA, valB, valC, valP, Instr_valid, imem_error,
        input  valE, cnd, valM, stat, PC
    );

    modport slave (
        input  icode, ifun, valA, valB, valC, valP, Instr_valid, imem_error,
        output valE, cnd, valM, stat, PC
    );
endinterface

// File: rtl/y86_exec_mem_pc.sv
// Y86-64 sequential execute, memory and PC-update stages with condition codes,
// byte-addressed data memory and sticky processor status.
module y86_exec_mem_pc #(
    parameter int N         = 64,
    parameter int MEM_BYTES = 1024
) (
    input logic               clk,
    input logic               rst,
    y86_exec_mem_pc_if.slave  bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [1:0] {
        S_AOK = 2'b00,
        S_HLT = 2'b01,
        S_ADR = 2'b10,
        S_INS = 2'b11
    } stat_e;

    logic [N-1:0] alu_e;
    logic         zf_q, sf_q, of_q;
    logic         zf_d, sf_d, of_d;
    logic         cnd_c;
    logic         rd_en, wr_en_raw, wr_en;
    logic [N-1:0] acc_addr;
    logic [N:0]   acc_end;
    logic         dmem_err;
    logic [AW-1:0] acc_idx;
    logic [N-1:0] wr_data;
    logic [N-1:0] rd_word;
    logic [N-1:0] valm_c;
    stat_e        stat_c;
    stat_e        stat_q;
    logic [7:0]   mem_q [MEM_BYTES];

    always_comb begin
        alu_e = '0;
        case (bus.icode)
            I_OPQ: begin
                case (bus.ifun)
                    4'h0:    alu_e = bus.valB + bus.valA;
                    4'h1:    alu_e = bus.valB - bus.valA;
                    4'h2:    alu_e = bus.valB & bus.valA;
                    4'h3:    alu_e = bus.valB ^ bus.valA;
                    default: alu_e = '0;
                endcase
            end
            I_CMOV:           alu_e = bus.valA;
            I_IRMOV:          alu_e = bus.valC;
            I_RMMOV, I_MRMOV: alu_e = bus.valB + bus.valC;
            I_CALL, I_PUSH:   alu_e = bus.valB - N'(8);
            I_RET, I_POP:     alu_e = bus.valB + N'(8);
            default:          alu_e = '0;
        endcase
    end

    always_comb begin
        zf_d = (alu_e == '0);
        sf_d = alu_e[N-1];
        case (bus.ifun)
            4'h0:    of_d = (bus.valA[N-1] == bus.valB[N-1]) && (alu_e[N-1] != bus.valA[N-1]);
            4'h1:    of_d = (bus.valA[N-1] != bus.valB[N-1]) && (alu_e[N-1] != bus.valB[N-1]);
            default: of_d = 1'b0;
        endcase
    end

    always_comb begin
        cnd_c = 1'b0;
        if (bus.icode == I_CMOV || bus.icode == I_JXX) begin
            case (bus.ifun)
                4'h0:    cnd_c = 1'b1;
                4'h1:    cnd_c = (sf_q ^ of_q) | zf_q;
                4'h2:    cnd_c = sf_q ^ of_q;
                4'h3:    cnd_c = zf_q;
                4'h4:    cnd_c = ~zf_q;
                4'h5:    cnd_c = ~(sf_q ^ of_q);
                4'h6:    cnd_c = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd_c = 1'b0;
            endcase
        end
    end

    // Only one access per instruction, so reads and writes share one address path.
    always_comb begin
        rd_en     = (bus.icode == I_MRMOV) || (bus.icode == I_RET) || (bus.icode == I_POP);
        wr_en_raw = (bus.icode == I_RMMOV) || (bus.icode == I_PUSH) || (bus.icode == I_CALL);
        acc_addr  = (bus.icode == I_RET || bus.icode == I_POP) ? bus.valA : alu_e;
        wr_data   = (bus.icode == I_CALL) ? bus.valP : bus.valA;
    end

    // Extra top bit makes an address that wraps past 2^N count as out of range.
    assign acc_end  = {1'b0, acc_addr} + (N+1)'(7);
    assign dmem_err = (rd_en || wr_en_raw) && (acc_end >= (N+1)'(MEM_BYTES));
    assign acc_idx  = acc_addr[AW-1:0];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem_q[acc_idx + AW'(i)];
        end
    end

    assign valm_c = (rd_en && !dmem_err) ? rd_word : '0;

    always_comb begin
        if (bus.imem_error)          stat_c = S_ADR;
        else if (!bus.Instr_valid)   stat_c = S_INS;
        else if (dmem_err)           stat_c = S_ADR;
        else if (bus.icode == I_HALT) stat_c = S_HLT;
        else                         stat_c = S_AOK;
    end

    assign wr_en = wr_en_raw && (stat_q == S_AOK) && (stat_c == S_AOK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= S_AOK;
            zf_q   <= 1'b1;
            sf_q   <= 1'b0;
            of_q   <= 1'b0;
        end else if (stat_q == S_AOK) begin
            stat_q <= stat_c;
            if (bus.icode == I_OPQ) begin
                zf_q <= zf_d;
                sf_q <= sf_d;
                of_q <= of_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[acc_idx + AW'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.valE = alu_e;
    assign bus.cnd  = cnd_c;
    assign bus.valM = valm_c;
    assign bus.stat = (stat_q != S_AOK) ? stat_q : stat_c;

    always_comb begin
        if (bus.icode == I_CALL)              bus.PC = bus.valC;
        else if (bus.icode == I_JXX && cnd_c) bus.PC = bus.valC;
        else if (bus.icode == I_RET)          bus.PC = valm_c;
        else                                  bus.PC = bus.valP;
    end
endmodule

// File: tb/tb_y86_exec_mem_pc.sv
// Random and directed checking of y86_exec_mem_pc against a behavioural Y86 model.
module tb_y86_exec_mem_pc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    y86_exec_mem_pc_if #(.N(64)) bus();

    y86_exec_mem_pc #(.N(64), .MEM_BYTES(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_mem [1024];
    bit          m_zf, m_sf, m_of;
    logic [1:0]  m_stat;

    logic [63:0] e_valE, e_valM, e_pc, e_waddr, e_wdata;
    logic        e_cnd, e_wr;
    logic [1:0]  e_stat, e_now;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_stat = 2'b00;
    endtask

    task automatic model_eval();
        logic [3:0]  ic, fn;
        logic [63:0] a, b, addr;
        bit          rd, derr, lt;
        ic = bus.icode; fn = bus.ifun; a = bus.valA; b = bus.valB;
        case (ic)
            4'h6: e_valE = (fn == 0) ? b + a : (fn == 1) ? b - a :
                           (fn == 2) ? (b & a) : (fn == 3) ? (b ^ a) : 64'd0;
            4'h2: e_valE = a;
            4'h3: e_valE = bus.valC;
            4'h4, 4'h5: e_valE = b + bus.valC;
            4'h8, 4'hA: e_valE = b - 64'd8;
            4'h9, 4'hB: e_valE = b + 64'd8;
            default: e_valE = 64'd0;
        endcase
        lt = m_sf != m_of;
        e_cnd = 1'b0;
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                0: e_cnd = 1'b1;
                1: e_cnd = lt || m_zf;
                2: e_cnd = lt;
                3: e_cnd = m_zf;
                4: e_cnd = !m_zf;
                5: e_cnd = !lt;
                6: e_cnd = !lt && !m_zf;
                default: e_cnd = 1'b0;
            endcase
        end
        rd      = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        e_wr    = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        e_waddr = e_valE;
        e_wdata = (ic == 4'h8) ? bus.valP : a;
        addr    = (ic == 4'h5) ? e_valE : rd ? a : e_valE;
        derr    = (rd || e_wr) && (addr > 64'd1016);
        e_valM  = 64'd0;
        if (rd && !derr)
            for (int i = 0; i < 8; i++) e_valM |= 64'(m_mem[int'(addr[9:0]) + i]) << (8 * i);
        if (bus.imem_error)        e_now = 2'b10;
        else if (!bus.Instr_valid) e_now = 2'b11;
        else if (derr)             e_now = 2'b10;
        else if (ic == 4'h0)       e_now = 2'b01;
        else                       e_now = 2'b00;
        e_stat = (m_stat != 2'b00) ? m_stat : e_now;
        if (ic == 4'h8 || (ic == 4'h7 && e_cnd)) e_pc = bus.valC;
        else if (ic == 4'h9)                     e_pc = e_valM;
        else                                     e_pc = bus.valP;
    endtask

    // Applies the effect of the coming rising edge with the inputs currently driven.
    task automatic model_edge();
        logic [64:0] s;
        if (!rst) return;
        model_eval();
        if (m_stat == 2'b00) begin
            if (bus.icode == 4'h6) begin
                m_zf = (e_valE == 64'd0);
                m_sf = e_valE[63];
                m_of = 1'b0;
                if (bus.ifun == 0) begin
                    s = {bus.valB[63], bus.valB} + {bus.valA[63], bus.valA};
                    m_of = s[64] != s[63];
                end else if (bus.ifun == 1) begin
                    s = {bus.valB[63], bus.valB} - {bus.valA[63], bus.valA};
                    m_of = s[64] != s[63];
                end
            end
            if (e_wr && e_now == 2'b00)
                for (int i = 0; i < 8; i++) m_mem[int'(e_waddr[9:0]) + i] = e_wdata[8*i +: 8];
            m_stat = e_now;
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [63:0] p,
                         input bit iv, input bit im);
        bus.icode = ic; bus.ifun = fn; bus.valA = a; bus.valB = b;
        bus.valC = c; bus.valP = p; bus.Instr_valid = iv; bus.imem_error = im;
    endtask

    task automatic check_model();
        model_eval();
        check_val("valE", bus.valE, e_valE);
        check_val("cnd",  64'(bus.cnd), 64'(e_cnd));
        check_val("valM", bus.valM, e_valM);
        check_val("stat", 64'(bus.stat), 64'(e_stat));
        check_val("PC",   bus.PC, e_pc);
    endtask

    task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [63:0] p,
                        input bit iv, input bit im);
        model_edge();
        @(negedge clk);
        drive(ic, fn, a, b, c, p, iv, im);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'h1, 4'h0, 0, 0, 0, 64'h10, 1'b1, 1'b0);
        #1;
        model_reset();
        check_val("rst_stat", 64'(bus.stat), 64'd0);
        drive(4'h7, 4'h3, 0, 0, 64'h40, 64'h10, 1'b1, 1'b0);
        #1;
        check_val("rst_je_cnd", 64'(bus.cnd), 64'd1);
        check_model();
        drive(4'h0, 4'h0, 0, 0, 0, 64'h10, 1'b1, 1'b0);
        #1;
        check_val("rst_halt_comb", 64'(bus.stat), 64'd1);
        drive(4'h1, 4'h0, 0, 0, 0, 64'h10, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] rnd_addr();
        if ($urandom_range(0, 19) == 0) return {$urandom, $urandom};
        return 64'($urandom_range(0, 40) * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0));
    endfunction

    initial begin
        drive(4'h1, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b1;

        step(4'h6, 4'h0, 64'd5, 64'd7, 0, 64'h2, 1, 0);
        check_val("add_valE", bus.valE, 64'd12);
        step(4'h7, 4'h3, 0, 0, 64'h40, 64'h20, 1, 0);
        check_val("je_cnd", 64'(bus.cnd), 64'd0);
        step(4'h7, 4'h4, 0, 0, 64'h40, 64'h20, 1, 0);
        check_val("jne_pc", bus.PC, 64'h40);

        step(4'h6, 4'h1, 64'd9, 64'd9, 0, 64'h2, 1, 0);
        check_val("sub_zero", bus.valE, 64'd0);
        step(4'h2, 4'h3, 64'hABC, 0, 0, 64'h2, 1, 0);
        check_val("cmove_cnd", 64'(bus.cnd), 64'd1);
        check_val("cmove_valE", bus.valE, 64'hABC);

        step(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 64'h2, 1, 0);
        check_val("ovf_valE", bus.valE, 64'h8000_0000_0000_0000);
        step(4'h7, 4'h2, 0, 0, 64'h80, 64'h20, 1, 0);
        check_val("jl_cnd", 64'(bus.cnd), 64'd0);
        step(4'h7, 4'h5, 0, 0, 64'h80, 64'h20, 1, 0);
        check_val("jge_cnd", 64'(bus.cnd), 64'd1);

        step(4'h4, 4'h0, 64'h1122_3344_5566_7788, 64'h100, 64'h8, 64'ha, 1, 0);
        check_val("rmmov_valE", bus.valE, 64'h108);
        step(4'h5, 4'h0, 0, 64'h100, 64'h8, 64'ha, 1, 0);
        check_val("mrmov_valM", bus.valM, 64'h1122_3344_5566_7788);
        step(4'hB, 4'h0, 64'h108, 64'h1000, 0, 64'h2, 1, 0);
        check_val("pop_valM", bus.valM, 64'h1122_3344_5566_7788);
        check_val("pop_valE", bus.valE, 64'h1008);

        step(4'h8, 4'h0, 0, 64'h200, 64'h40, 64'h15, 1, 0);
        check_val("call_valE", bus.valE, 64'h1F8);
        check_val("call_pc", bus.PC, 64'h40);
        step(4'h9, 4'h0, 64'h1F8, 64'h1F8, 0, 64'h1, 1, 0);
        check_val("ret_valE", bus.valE, 64'h200);
        check_val("ret_valM", bus.valM, 64'h15);
        check_val("ret_pc", bus.PC, 64'h15);

        step(4'h5, 4'h0, 0, 64'h3FC, 0, 64'ha, 1, 0);
        check_val("derr_stat", 64'(bus.stat), 64'd2);
        check_val("derr_valM", bus.valM, 64'd0);
        step(4'h1, 4'h0, 0, 0, 0, 64'h2, 1, 0);
        check_val("sticky_stat", 64'(bus.stat), 64'd2);
        step(4'h6, 4'h1, 64'd3, 64'd3, 0, 64'h2, 1, 0);
        step(4'h7, 4'h3, 0, 0, 64'h40, 64'h20, 1, 0);
        check_val("frozen_cc_je", 64'(bus.cnd), 64'd0);
        do_reset();

        step(4'h0, 4'h0, 0, 0, 0, 64'h2, 1, 0);
        check_val("halt_stat", 64'(bus.stat), 64'd1);
        do_reset();
        step(4'h1, 4'h0, 0, 0, 0, 64'h2, 0, 0);
        check_val("ins_stat", 64'(bus.stat), 64'd3);
        do_reset();
        step(4'h1, 4'h0, 0, 0, 0, 64'h2, 0, 1);
        check_val("imem_stat", 64'(bus.stat), 64'd2);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            if (n % 64 == 63) begin
                do_reset();
            end else begin
                logic [3:0] ic;
                ic = ($urandom_range(0, 99) < 2) ? 4'h0 : 4'($urandom_range(1, 11));
                step(ic, 4'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 0) ? rnd_addr() : {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : rnd_addr(),
                     ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom},
                     {$urandom, $urandom},
                     $urandom_range(0, 99) != 0, $urandom_range(0, 99) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
